ex_me_stage_reg: RTL

Parametrised EX->MEM pipeline stage register with a valid/ready handshake, stall support, synchronous flush and bubble insertion.
An optional skid buffer (SKID=1) keeps ex_ready a registered signal, which breaks the backpressure timing path from the MEM stage.
It sits between the ALU/EX stage and the data-memory stage and carries the ALU result, store data, destination register, control bits and the instruction word.

---
 rtl/ex_me_stage_reg.sv | 121 ++++++++++++
 1 files changed

// File: rtl/ex_me_stage_reg.sv
// rtl/ex_me_stage_reg.sv - EX->MEM pipeline stage register with valid/ready handshake,
// flush, bubble insertion and an optional 2-entry skid buffer.
module ex_me_stage_reg #(
  parameter int                 DATA_W    = 32,
  parameter int                 RADDR_W   = 5,
  parameter int                 INSTR_W   = 32,
  parameter logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0020,
  parameter int                 SKID      = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               ex_valid,
  output logic               ex_ready,
  input  logic [DATA_W-1:0]  ex_aluresult,
  input  logic [DATA_W-1:0]  ex_d2,
  input  logic [INSTR_W-1:0] ex_instr,
  input  logic [RADDR_W-1:0] ex_td,
  input  logic               ex_WREG,
  input  logic               ex_WMEM,
  input  logic               ex_LW,
  output logic               me_valid,
  input  logic               me_ready,
  output logic [DATA_W-1:0]  me_aluresult,
  output logic [DATA_W-1:0]  me_d2,
  output logic [INSTR_W-1:0] me_instr,
  output logic [RADDR_W-1:0] me_td,
  output logic               me_WREG,
  output logic               me_WMEM,
  output logic               me_LW,
  output logic [1:0]         occupancy
);

  localparam bit USE_SKID = (SKID != 0);
  localparam int EW       = 2*DATA_W + INSTR_W + RADDR_W + 3;

  logic          skid_full;
  logic          skid_full_nxt;
  logic [EW-1:0] skid_bus;
  logic [EW-1:0] in_bus;
  logic [EW-1:0] load_bus;
  logic          out_free;
  logic          accept;

  logic [DATA_W-1:0]  ld_aluresult;
  logic [DATA_W-1:0]  ld_d2;
  logic [INSTR_W-1:0] ld_instr;
  logic [RADDR_W-1:0] ld_td;
  logic               ld_wreg;
  logic               ld_wmem;
  logic               ld_lw;

  assign out_free = !me_valid | me_ready;
  // With the skid buffer, ex_ready comes straight from a flop, so MEM backpressure never reaches EX combinationally.
  assign ex_ready = USE_SKID ? !skid_full : out_free;
  assign accept   = ex_valid & ex_ready;

  assign in_bus   = {ex_aluresult, ex_d2, ex_instr, ex_td, ex_WREG, ex_WMEM, ex_LW};
  assign load_bus = skid_full ? skid_bus : in_bus;
  assign {ld_aluresult, ld_d2, ld_instr, ld_td, ld_wreg, ld_wmem, ld_lw} = load_bus;

  assign occupancy = {1'b0, me_valid} + {1'b0, skid_full};

  always_comb begin
    skid_full_nxt = skid_full;
    if (!USE_SKID) begin
      skid_full_nxt = 1'b0;
    end else if (out_free) begin
      skid_full_nxt = skid_full & accept;
    end else if (accept) begin
      skid_full_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      me_valid     <= 1'b0;
      me_aluresult <= '0;
      me_d2        <= '0;
      me_instr     <= NOP_INSTR;
      me_td        <= '0;
      me_WREG      <= 1'b0;
      me_WMEM      <= 1'b0;
      me_LW        <= 1'b0;
      skid_full    <= 1'b0;
      skid_bus     <= '0;
    end else if (flush) begin
      me_valid  <= 1'b0;
      me_instr  <= NOP_INSTR;
      me_WREG   <= 1'b0;
      me_WMEM   <= 1'b0;
      me_LW     <= 1'b0;
      skid_full <= 1'b0;
    end else begin
      if (out_free) begin
        if (skid_full || accept) begin
          me_valid     <= 1'b1;
          me_aluresult <= ld_aluresult;
          me_d2        <= ld_d2;
          me_instr     <= ld_instr;
          me_td        <= ld_td;
          me_WREG      <= ld_wreg;
          me_WMEM      <= ld_wmem;
          me_LW        <= ld_lw;
        end else begin
          // Bubble: data fields keep their last values, only control and instr go to NOP.
          me_valid <= 1'b0;
          me_instr <= NOP_INSTR;
          me_WREG  <= 1'b0;
          me_WMEM  <= 1'b0;
          me_LW    <= 1'b0;
        end
      end
      skid_full <= skid_full_nxt;
      if (USE_SKID && accept && !(out_free && !skid_full)) begin
        skid_bus <= in_bus;
      end
    end
  end

endmodule
